enemy2_control: RTL and testbench

ENEMY2_CONTROL -- requirements
Module: enemy2_control

---
 rtl/enemy2_control.sv | 189 ++++++++++++++++++
 tb/tb_enemy2_control.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy2_control.sv
// ---------------------------------------------------------------------------
// enemy2_control
//
// Control FSM for the second enemy sprite. It sequences the datapath through
// respawn, colour load, a 4x4 sprite draw, an on-screen hold, an erase, and a
// one-row move. After each move it checks whether the enemy has reached the
// bottom limit and, if so, respawns it. The draw and erase phases share the
// VGA write port through a plot arbiter, so they only advance on a grant.
//
// Parameters
//   DELAY_TICKS : delay_cnt value that ends the on-screen hold
//   Y_LIMIT     : top-row Y at or beyond which the enemy respawns
//
// Ports
//   clock        : system clock, all state changes on its rising edge
//   resetn       : synchronous active-low reset
//   go           : start the animation, looked at only while idle
//   gnt          : VGA write grant from the shared plot arbiter
//   cnt          : 4x4 sprite pixel index from the datapath
//   delay_cnt    : delayed frame counter from the datapath
//   y_in         : current sprite top-row Y from the datapath
//   hit          : (only with ENEMY2_CTRL_HIT_EN) enemy was hit, erase early
//   loadX/loadY/load_colour/load_black : datapath load strobes
//   en_counter/en_delay_counter        : datapath counter enables
//   reset_delay  : active-low clear of the delayed counter
//   req          : plot request to the arbiter
//   plot         : VGA write enable
//   respawned    : one-cycle pulse when a new X is loaded
//   dbg_state    : current FSM state, for observation only
//
// Optional feature macro: ENEMY2_CTRL_HIT_EN (adds the hit input).
//
// Handshake: req is held high for the whole of DRAW and ERASE. A pixel is
// written, and cnt advances, only in a cycle where req and gnt are both high;
// with gnt low the FSM waits indefinitely without dropping req.
// ---------------------------------------------------------------------------
module enemy2_control #(
  parameter logic [3:0] DELAY_TICKS = 4'd15,
  parameter logic [6:0] Y_LIMIT     = 7'd116
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       go,
  input  logic       gnt,
  input  logic [3:0] cnt,
  input  logic [3:0] delay_cnt,
  input  logic [6:0] y_in,
`ifdef ENEMY2_CTRL_HIT_EN
  input  logic       hit,
`endif
  output logic       loadX,
  output logic       loadY,
  output logic       load_colour,
  output logic       load_black,
  output logic       en_counter,
  output logic       en_delay_counter,
  output logic       reset_delay,
  output logic       req,
  output logic       plot,
  output logic       respawned,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESPAWN = 3'd1,
    S_COLOUR  = 3'd2,
    S_DRAW    = 3'd3,
    S_HOLD    = 3'd4,
    S_ERASE   = 3'd5,
    S_MOVE    = 3'd6,
    S_CHECK   = 3'd7
  } state_t;

  state_t state;

  // Last pixel of the 4x4 sprite is being written this cycle.
  logic last_pixel;
  assign last_pixel = gnt && (cnt == 4'd15);

`ifdef ENEMY2_CTRL_HIT_EN
  // Remembers that the current erase was caused by a hit, so the erase
  // finishes into a fresh respawn instead of a move.
  logic hit_pending;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_IDLE;
`ifdef ENEMY2_CTRL_HIT_EN
      hit_pending <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (go) state <= S_RESPAWN;
        end
        S_RESPAWN: begin
          state <= S_COLOUR;
`ifdef ENEMY2_CTRL_HIT_EN
          hit_pending <= 1'b0;
`endif
        end
        S_COLOUR: begin
          state <= S_DRAW;
        end
        S_DRAW: begin
`ifdef ENEMY2_CTRL_HIT_EN
          if (hit) begin
            state       <= S_ERASE;
            hit_pending <= 1'b1;
          end else
`endif
          if (last_pixel) state <= S_HOLD;
        end
        S_HOLD: begin
`ifdef ENEMY2_CTRL_HIT_EN
          if (hit) begin
            state       <= S_ERASE;
            hit_pending <= 1'b1;
          end else
`endif
          if (delay_cnt == DELAY_TICKS) state <= S_ERASE;
        end
        S_ERASE: begin
          if (last_pixel) begin
`ifdef ENEMY2_CTRL_HIT_EN
            state <= hit_pending ? S_RESPAWN : S_MOVE;
`else
            state <= S_MOVE;
`endif
          end
        end
        S_MOVE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          // y_in already reflects the row loaded during MOVE.
          if (y_in >= Y_LIMIT) state <= S_RESPAWN;
          else                 state <= S_DRAW;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the state register; only plot and en_counter also look
  // at gnt, so a pixel is never written without the arbiter's grant.
  always_comb begin
    loadX            = 1'b0;
    loadY            = 1'b0;
    load_colour      = 1'b0;
    load_black       = 1'b0;
    en_counter       = 1'b0;
    en_delay_counter = 1'b0;
    reset_delay      = 1'b0;
    req              = 1'b0;
    plot             = 1'b0;
    respawned        = 1'b0;
    case (state)
      S_RESPAWN: begin
        loadX     = 1'b1;
        respawned = 1'b1;
      end
      S_COLOUR: load_colour = 1'b1;
      S_DRAW: begin
        req        = 1'b1;
        plot       = gnt;
        en_counter = gnt;
      end
      S_HOLD: begin
        // Releasing the clear only here makes every hold start from zero.
        en_delay_counter = 1'b1;
        reset_delay      = 1'b1;
      end
      S_ERASE: begin
        req        = 1'b1;
        load_black = 1'b1;
        plot       = gnt;
        en_counter = gnt;
      end
      S_MOVE: loadY = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_enemy2_control.sv
// ---------------------------------------------------------------------------
// tb_enemy2_control
//
// Bench for enemy2_control (instantiated with DELAY_TICKS = 3). A directed
// vector table walks the full animation loop, hand-written sequences cover
// grant throttling, reset in the middle of an erase and (when the hit
// feature is compiled in) an early erase on hit, and a randomized run is
// compared cycle by cycle against a phase-level reference model.
// ---------------------------------------------------------------------------
module tb_enemy2_control;

  localparam logic [3:0] DT = 4'd3;
  localparam logic [6:0] YL = 7'd116;
`ifdef ENEMY2_CTRL_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  // Output vector bit positions.
  localparam logic [9:0] O_LX   = 10'b1000000000;
  localparam logic [9:0] O_LY   = 10'b0100000000;
  localparam logic [9:0] O_LC   = 10'b0010000000;
  localparam logic [9:0] O_LB   = 10'b0001000000;
  localparam logic [9:0] O_EN   = 10'b0000100000;
  localparam logic [9:0] O_ED   = 10'b0000010000;
  localparam logic [9:0] O_RD   = 10'b0000001000;
  localparam logic [9:0] O_REQ  = 10'b0000000100;
  localparam logic [9:0] O_PLOT = 10'b0000000010;
  localparam logic [9:0] O_RSP  = 10'b0000000001;

  // Animation phases of the reference model.
  localparam int P_IDLE = 0, P_RESPAWN = 1, P_COLOUR = 2, P_DRAW = 3,
                 P_HOLD = 4, P_ERASE = 5, P_MOVE = 6, P_CHECK = 7;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       resetn, go, gnt, hit;
  logic [3:0] cnt, delay_cnt;
  logic [6:0] y_in;
  logic       loadX, loadY, load_colour, load_black, en_counter;
  logic       en_delay_counter, reset_delay, req, plot, respawned;
  logic [2:0] dbg_state;
  logic [9:0] act;

  always #5 clock = ~clock;

  enemy2_control #(.DELAY_TICKS(DT), .Y_LIMIT(YL)) dut (
    .clock(clock), .resetn(resetn), .go(go), .gnt(gnt), .cnt(cnt),
    .delay_cnt(delay_cnt), .y_in(y_in),
`ifdef ENEMY2_CTRL_HIT_EN
    .hit(hit),
`endif
    .loadX(loadX), .loadY(loadY), .load_colour(load_colour),
    .load_black(load_black), .en_counter(en_counter),
    .en_delay_counter(en_delay_counter), .reset_delay(reset_delay),
    .req(req), .plot(plot), .respawned(respawned), .dbg_state(dbg_state)
  );

  assign act = {loadX, loadY, load_colour, load_black, en_counter,
                en_delay_counter, reset_delay, req, plot, respawned};

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_act;

  task automatic check(input string name, input logic [9:0] a, input logic [9:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, a, e);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase    = P_IDLE;
  bit m_hit      = 1'b0;
  bit m_valid    = 1'b0;

  function automatic logic [9:0] exp_out(input int ph, input logic g);
    logic [9:0] wr;
    wr = g ? (O_PLOT | O_EN) : 10'd0;
    case (ph)
      P_RESPAWN: return O_LX | O_RSP;
      P_COLOUR:  return O_LC;
      P_DRAW:    return O_REQ | wr;
      P_HOLD:    return O_ED | O_RD;
      P_ERASE:   return O_REQ | O_LB | wr;
      P_MOVE:    return O_LY;
      default:   return 10'd0;
    endcase
  endfunction

  task automatic model_step(input logic rn, g, gt, input logic [3:0] c, dc,
                            input logic [6:0] y, input logic h);
    bit sprite_done;
    bit hit_now;
    sprite_done = gt && (c == 4'd15);
    hit_now     = HIT_EN && h;
    if (!rn) begin
      m_phase = P_IDLE;
      m_hit   = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE:    if (g) m_phase = P_RESPAWN;
        P_RESPAWN: begin m_phase = P_COLOUR; m_hit = 1'b0; end
        P_COLOUR:  m_phase = P_DRAW;
        P_DRAW:    if (hit_now) begin m_phase = P_ERASE; m_hit = 1'b1; end
                   else if (sprite_done) m_phase = P_HOLD;
        P_HOLD:    if (hit_now) begin m_phase = P_ERASE; m_hit = 1'b1; end
                   else if (dc == DT) m_phase = P_ERASE;
        P_ERASE:   if (sprite_done) m_phase = m_hit ? P_RESPAWN : P_MOVE;
        P_MOVE:    m_phase = P_CHECK;
        default:   m_phase = (y >= YL) ? P_RESPAWN : P_DRAW;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs just after an edge, sample outputs before the next edge.
  task automatic cycle(input logic rn, g, gt, input logic [3:0] c, dc,
                       input logic [6:0] y, input logic h, input string tag);
    resetn = rn; go = g; gnt = gt; cnt = c; delay_cnt = dc; y_in = y; hit = h;
    #2;
    last_act = act;
    if (m_valid) begin
      exp_q.push_back(exp_out(m_phase, gt));
      check(tag, last_act, exp_q.pop_front());
    end
    model_step(rn, g, gt, c, dc, y, h);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 7'd0, 1'b0, "reset");
    m_valid = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rn, g, gt;
    logic [3:0] c, dc;
    logic [6:0] y;
    logic [9:0] e;
  } vec_t;

  vec_t tbl[23];

  task automatic set_vec(input int i, input logic rn, g, gt, input logic [3:0] c, dc,
                         input logic [6:0] y, input logic [9:0] e);
    tbl[i].rn = rn; tbl[i].g = g; tbl[i].gt = gt;
    tbl[i].c = c; tbl[i].dc = dc; tbl[i].y = y; tbl[i].e = e;
  endtask

  initial begin
    logic [3:0] cnt_dp;
    int plots, req_low;
    logic [9:0] seen;

    resetn = 1'b0; go = 1'b0; gnt = 1'b0; hit = 1'b0;
    cnt = 4'd0; delay_cnt = 4'd0; y_in = 7'd0;
    #1;

    //          i  rn g  gt  c      dc     y        expected
    set_vec( 0, 1, 1, 0, 4'd0,  4'd0,  7'd0,   10'd0);                 // idle, go
    set_vec( 1, 1, 0, 0, 4'd0,  4'd0,  7'd0,   O_LX | O_RSP);          // respawn
    set_vec( 2, 1, 0, 0, 4'd0,  4'd0,  7'd0,   O_LC);                  // colour
    set_vec( 3, 1, 0, 0, 4'd15, 4'd0,  7'd0,   O_REQ);                 // draw, no grant
    set_vec( 4, 1, 0, 1, 4'd3,  4'd0,  7'd0,   O_REQ | O_PLOT | O_EN);
    set_vec( 5, 1, 0, 1, 4'd15, 4'd0,  7'd0,   O_REQ | O_PLOT | O_EN); // last pixel
    set_vec( 6, 1, 0, 0, 4'd0,  4'd0,  7'd0,   O_ED | O_RD);           // hold
    set_vec( 7, 1, 0, 0, 4'd0,  4'd2,  7'd0,   O_ED | O_RD);
    set_vec( 8, 1, 0, 0, 4'd0,  4'd3,  7'd0,   O_ED | O_RD);           // hold ends
    set_vec( 9, 1, 0, 0, 4'd15, 4'd0,  7'd0,   O_REQ | O_LB);          // erase, no grant
    set_vec(10, 1, 0, 1, 4'd15, 4'd0,  7'd0,   O_REQ | O_LB | O_PLOT | O_EN);
    set_vec(11, 1, 0, 0, 4'd0,  4'd0,  7'd0,   O_LY);                  // move
    set_vec(12, 1, 0, 0, 4'd0,  4'd0,  7'd115, 10'd0);                 // check, stay
    set_vec(13, 1, 0, 1, 4'd15, 4'd0,  7'd115, O_REQ | O_PLOT | O_EN); // draw, no colour
    set_vec(14, 1, 0, 0, 4'd0,  4'd3,  7'd0,   O_ED | O_RD);
    set_vec(15, 1, 0, 1, 4'd15, 4'd0,  7'd0,   O_REQ | O_LB | O_PLOT | O_EN);
    set_vec(16, 1, 0, 0, 4'd0,  4'd0,  7'd0,   O_LY);
    set_vec(17, 1, 0, 0, 4'd0,  4'd0,  7'd116, 10'd0);                 // check, limit
    set_vec(18, 1, 0, 0, 4'd0,  4'd0,  7'd0,   O_LX | O_RSP);
    set_vec(19, 1, 0, 0, 4'd0,  4'd0,  7'd0,   O_LC);
    set_vec(20, 0, 0, 1, 4'd5,  4'd0,  7'd0,   O_REQ | O_PLOT | O_EN); // reset mid-draw
    set_vec(21, 1, 0, 1, 4'd5,  4'd0,  7'd0,   10'd0);
    set_vec(22, 1, 0, 1, 4'd15, 4'd3,  7'd0,   10'd0);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].rn, tbl[i].g, tbl[i].gt, tbl[i].c, tbl[i].dc, tbl[i].y, 1'b0,
            $sformatf("model_vec%0d", i));
      check($sformatf("vec%0d", i), last_act, tbl[i].e);
    end

    // ---- grant toggling during DRAW: 16 plots in 32 cycles, req held ----
    do_reset();
    cycle(1, 1, 0, 4'd0, 4'd0, 7'd0, 0, "tog_go");
    cycle(1, 0, 0, 4'd0, 4'd0, 7'd0, 0, "tog_respawn");
    cycle(1, 0, 0, 4'd0, 4'd0, 7'd0, 0, "tog_colour");
    cnt_dp = 4'd0; plots = 0; req_low = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, logic'(i % 2), cnt_dp, 4'd0, 7'd0, 0, "tog_draw");
      if (last_act[1]) begin plots++; cnt_dp = cnt_dp + 4'd1; end
      if (!last_act[2]) req_low++;
    end
    check("tog_plot_count", 10'(plots), 10'd16);
    check("tog_req_low_cycles", 10'(req_low), 10'd0);
    cycle(1, 0, 1, 4'd0, 4'd0, 7'd0, 0, "tog_hold");
    check("tog_then_hold", last_act, O_ED | O_RD);

    // ---- reset asserted on the 7th ERASE cycle ----
    do_reset();
    cycle(1, 1, 0, 4'd0,  4'd0, 7'd0, 0, "rst_go");
    cycle(1, 0, 0, 4'd0,  4'd0, 7'd0, 0, "rst_respawn");
    cycle(1, 0, 0, 4'd0,  4'd0, 7'd0, 0, "rst_colour");
    cycle(1, 0, 1, 4'd15, 4'd0, 7'd0, 0, "rst_draw");
    cycle(1, 0, 0, 4'd0,  4'd3, 7'd0, 0, "rst_hold");
    for (int i = 0; i < 7; i++)
      cycle((i == 6) ? 1'b0 : 1'b1, 0, 1, 4'(i), 4'd0, 7'd0, 0, "rst_erase");
    cycle(1, 0, 1, 4'd15, 4'd3, 7'd120, 0, "rst_after");
    check("rst_after_erase_quiet", last_act, 10'd0);
    seen = 10'd0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 1, 4'd15, 4'd3, 7'd120, 0, "rst_idle");
      seen = seen | last_act;
    end
    check("rst_no_strobes_until_go", seen, 10'd0);

`ifdef ENEMY2_CTRL_HIT_EN
    // ---- hit during HOLD: early erase, then respawn without a move ----
    do_reset();
    cycle(1, 1, 0, 4'd0,  4'd0, 7'd0, 0, "hit_go");
    cycle(1, 0, 0, 4'd0,  4'd0, 7'd0, 0, "hit_respawn");
    cycle(1, 0, 0, 4'd0,  4'd0, 7'd0, 0, "hit_colour");
    cycle(1, 0, 1, 4'd15, 4'd0, 7'd0, 0, "hit_draw");
    cycle(1, 0, 0, 4'd0,  4'd0, 7'd0, 1, "hit_hold");
    cycle(1, 0, 1, 4'd15, 4'd0, 7'd0, 0, "hit_erase");
    check("hit_erase_out", last_act, O_REQ | O_LB | O_PLOT | O_EN);
    cycle(1, 0, 0, 4'd0,  4'd0, 7'd0, 0, "hit_after");
    check("hit_respawn_no_move", last_act, O_LX | O_RSP);
`endif

    // ---- randomized run against the reference model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rn, g, gt, h;
      logic [3:0] c, dc;
      logic [6:0] y;
      rn = ($urandom_range(0, 199) != 0);
      g  = ($urandom_range(0, 3) == 0);
      gt = ($urandom_range(0, 2) != 0);
      c  = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      dc = ($urandom_range(0, 2) == 0) ? DT : 4'($urandom_range(0, 15));
      y  = 7'($urandom_range(110, 122));
      h  = ($urandom_range(0, 15) == 0);
      cycle(rn, g, gt, c, dc, y, h, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
